// File: rtl/regfilemux.sv
// Register-file write-back source select shared by the decoder and the back end.
package regfilemux;

  typedef enum logic [3:0] {
    alu_out,
    br_en,
    u_imm,
    lw,
    pc_plus4,
    lb,
    lbu,
    lh,
    lhu,
    mul,
    mulh,
    div,
    rem
  } regfilemux_sel_t;

endpackage

// File: rtl/rv32i_types.sv
// RV32I opcode, ALU and control-word types plus the decode-queue entry format.
package rv32i_types;

  localparam int unsigned DECODE_WIDTH_MAX = 4;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic {
    a1_rs1,
    a1_pc
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    a2_i_imm,
    a2_u_imm,
    a2_b_imm,
    a2_s_imm,
    a2_j_imm,
    a2_rs2
  } alumux2_sel_t;

  typedef enum logic {
    cmp_rs2,
    cmp_i_imm
  } cmpmux_sel_t;

  typedef struct packed {
    rv32i_opcode                 opcode;
    logic [2:0]                  funct3;
    logic [4:0]                  rs1;
    logic [4:0]                  rs2;
    logic [4:0]                  rd;
    alu_ops                      aluop;
    branch_funct3_t              cmpop;
    alumux1_sel_t                alumux1_sel;
    alumux2_sel_t                alumux2_sel;
    cmpmux_sel_t                 cmpmux_sel;
    regfilemux::regfilemux_sel_t regfilemux_sel;
    logic                        load_regfile;
    logic                        mem_read;
    logic                        mem_write;
    logic                        multiplier_start;
    logic                        divider_start;
    logic                        rd_valid;
    logic                        commit;
  } rv32i_ctrl_word;

  typedef struct packed {
    logic [31:0]    pc;
    logic [31:0]    instr;
    rv32i_ctrl_word ctrl;
    logic           illegal;
  } decode_entry_t;

endpackage

// File: rtl/rv32_decoder.sv
// Combinational RV32I instruction decoder producing a control word and illegal flag.
// RV32M_EN enables the M-extension multiply/divide encodings.
module rv32_decoder
  import rv32i_types::*;
(
  input  logic [31:0]    instr,
  output rv32i_ctrl_word ctrl,
  output logic           illegal
);

  logic [2:0] funct3;
  logic [6:0] funct7;

  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl        = '0;
    illegal     = 1'b0;
    ctrl.opcode = rv32i_opcode'(instr[6:0]);
    ctrl.funct3 = funct3;
    ctrl.rs1    = instr[19:15];
    ctrl.rs2    = instr[24:20];
    ctrl.rd     = instr[11:7];
    ctrl.commit = 1'b1;

    case (instr[6:0])
      op_lui: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = regfilemux::u_imm;
      end
      op_auipc: begin
        ctrl.load_regfile = 1'b1;
        ctrl.alumux1_sel  = a1_pc;
        ctrl.alumux2_sel  = a2_u_imm;
      end
      op_jal: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = regfilemux::pc_plus4;
        ctrl.alumux1_sel    = a1_pc;
        ctrl.alumux2_sel    = a2_j_imm;
      end
      op_jalr: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = regfilemux::pc_plus4;
        ctrl.alumux2_sel    = a2_i_imm;
      end
      op_br: begin
        ctrl.cmpop       = branch_funct3_t'(funct3);
        ctrl.alumux1_sel = a1_pc;
        ctrl.alumux2_sel = a2_b_imm;
      end
      op_load: begin
        ctrl.load_regfile = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.alumux2_sel  = a2_i_imm;
        case (funct3)
          3'b000:  ctrl.regfilemux_sel = regfilemux::lb;
          3'b001:  ctrl.regfilemux_sel = regfilemux::lh;
          3'b010:  ctrl.regfilemux_sel = regfilemux::lw;
          3'b100:  ctrl.regfilemux_sel = regfilemux::lbu;
          3'b101:  ctrl.regfilemux_sel = regfilemux::lhu;
          default: illegal = 1'b1;
        endcase
      end
      op_store: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alumux2_sel = a2_s_imm;
        if (funct3 >= 3'b011) illegal = 1'b1;
      end
      op_imm: begin
        ctrl.load_regfile = 1'b1;
        ctrl.alumux2_sel  = a2_i_imm;
        ctrl.aluop        = alu_ops'(funct3);
        case (funct3)
          3'b010, 3'b011: begin
            ctrl.cmpop          = funct3[0] ? bltu : blt;
            ctrl.cmpmux_sel     = cmp_i_imm;
            ctrl.regfilemux_sel = regfilemux::br_en;
          end
          3'b001:  if (funct7 != 7'b0000000) illegal = 1'b1;
          3'b101: begin
            if (funct7 == 7'b0100000)      ctrl.aluop = alu_sra;
            else if (funct7 != 7'b0000000) illegal = 1'b1;
          end
          default: ;
        endcase
      end
      op_reg: begin
        ctrl.load_regfile = 1'b1;
        ctrl.alumux2_sel  = a2_rs2;
        ctrl.aluop        = alu_ops'(funct3);
        case (funct7)
          7'b0000000: begin
            if (funct3 == 3'b010 || funct3 == 3'b011) begin
              ctrl.cmpop          = funct3[0] ? bltu : blt;
              ctrl.cmpmux_sel     = cmp_rs2;
              ctrl.regfilemux_sel = regfilemux::br_en;
            end
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      ctrl.aluop = alu_sub;
            else if (funct3 == 3'b101) ctrl.aluop = alu_sra;
            else                       illegal = 1'b1;
          end
`ifdef RV32M_EN
          7'b0000001: begin
            // funct3[2] splits the M group into multiply (0xx) and divide (1xx)
            if (funct3[2]) begin
              ctrl.divider_start  = 1'b1;
              ctrl.regfilemux_sel = funct3[1] ? regfilemux::rem : regfilemux::div;
            end else begin
              ctrl.multiplier_start = 1'b1;
              ctrl.regfilemux_sel   = (funct3 == 3'b000) ? regfilemux::mul : regfilemux::mulh;
            end
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      op_csr: ;
      default: illegal = 1'b1;
    endcase

    ctrl.rd_valid = ctrl.load_regfile;

    if (illegal) begin
      ctrl.load_regfile     = 1'b0;
      ctrl.mem_read         = 1'b0;
      ctrl.mem_write        = 1'b0;
      ctrl.multiplier_start = 1'b0;
      ctrl.divider_start    = 1'b0;
      ctrl.rd_valid         = 1'b0;
      ctrl.commit           = 1'b1;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Multi-lane decode stage: decodes up to WIDTH instructions per cycle into a circular buffer
// and presents them in order to issue. RV32M_EN (in rv32_decoder) enables M-extension decode.
module decode_queue
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              in_valid,
  input  logic [WIDTH-1:0][31:0]        in_instr,
  input  logic [WIDTH-1:0][31:0]        in_pc,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              out_valid,
  output decode_entry_t [WIDTH-1:0]     out_entry,
  input  logic [$clog2(WIDTH+1)-1:0]    out_take
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned TakeW = $clog2(WIDTH + 1);

  decode_entry_t                 entry_q [DEPTH];
  logic [PtrW-1:0]               head_q, head_d;
  logic [PtrW-1:0]               tail_q, tail_d;
  logic [CntW-1:0]               count_q, count_d;

  rv32i_ctrl_word [WIDTH-1:0]    dec_ctrl;
  logic [WIDTH-1:0]              dec_illegal;
  decode_entry_t [WIDTH-1:0]     wr_entry;
  logic [TakeW-1:0]              n_in;
  logic [CntW-1:0]               n_out;
  logic [CntW-1:0]               take_ext;
  logic                          run;

  for (genvar k = 0; k < WIDTH; k++) begin : g_dec
    rv32_decoder u_dec (
      .instr   (in_instr[k]),
      .ctrl    (dec_ctrl[k]),
      .illegal (dec_illegal[k])
    );

    always_comb begin
      wr_entry[k].pc      = in_pc[k];
      wr_entry[k].instr   = in_instr[k];
      wr_entry[k].ctrl    = dec_ctrl[k];
      wr_entry[k].illegal = dec_illegal[k];
    end
  end

  // Ready depends only on registered occupancy so issue never feeds back into fetch.
  assign in_ready = (CntW'(DEPTH) - count_q) >= CntW'(WIDTH);

  // Only the leading run of valid lanes is accepted.
  always_comb begin
    n_in = '0;
    run  = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      run = run & in_valid[k];
      if (run) n_in = n_in + TakeW'(1);
    end
    if (!in_ready || flush || rst) n_in = '0;
  end

  always_comb begin
    take_ext = CntW'(out_take);
    n_out    = take_ext;
    if (n_out > count_q)        n_out = count_q;
    if (n_out > CntW'(WIDTH))   n_out = CntW'(WIDTH);
    if (flush || rst)           n_out = '0;
  end

  always_comb begin
    head_d  = head_q + PtrW'(n_out);
    tail_d  = tail_q + PtrW'(n_in);
    count_d = count_q + CntW'(n_in) - n_out;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < WIDTH; k++) begin
      if (TakeW'(k) < n_in) entry_q[tail_q + PtrW'(k)] <= wr_entry[k];
    end
  end

  // Invalid lanes read as zero so stale buffer contents never leak to issue.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      out_valid[i] = count_q > CntW'(i);
      out_entry[i] = out_valid[i] ? entry_q[head_q + PtrW'(i)] : '0;
    end
  end

  assert property (@(posedge clk) disable iff (rst || flush) take_ext <= count_q)
    else $error("decode_queue: out_take %0d exceeds count %0d", take_ext, count_q);

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue (WIDTH=2, DEPTH=8); honours RV32M_EN for the MUL case.
module tb_decode_queue;
  import rv32i_types::*;

  localparam int WIDTH = 2;
  localparam int DEPTH = 8;

  localparam logic [31:0] ADDI   = 32'h0050_0093;
  localparam logic [31:0] SUB    = 32'h4010_8133;
  localparam logic [31:0] MUL    = 32'h0220_8033;
  localparam logic [31:0] BADOP  = 32'h0000_007F;
  localparam logic [31:0] LW     = 32'h0000_A083;
  localparam logic [31:0] LWBAD  = 32'h0000_B083;
  localparam logic [31:0] SW     = 32'h0010_2023;
  localparam logic [31:0] SWBAD  = 32'h0010_3023;
  localparam logic [31:0] SLT    = 32'h0031_20B3;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] SRAI   = 32'h4010_D093;
  localparam logic [31:0] SLLBAD = 32'h4010_9093;
`ifdef RV32M_EN
  localparam logic MUL_ILL = 1'b0;
`else
  localparam logic MUL_ILL = 1'b1;
`endif

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      flush = 1'b0;
  logic [1:0]                in_valid = '0;
  logic [1:0][31:0]          in_instr = '0;
  logic [1:0][31:0]          in_pc = '0;
  logic                      in_ready;
  logic [1:0]                out_valid;
  decode_entry_t [1:0]       out_entry;
  logic [1:0]                out_take = '0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        illegal;
  } sb_t;

  sb_t sb[$];
  int  mcount = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  decode_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_entry (out_entry),
    .out_take  (out_take)
  );

  // Checks registered outputs against the model, then drives one cycle of stimulus.
  task automatic cycle(input logic [1:0] vld, input logic [31:0] i0, input logic [31:0] p0,
                       input logic il0, input logic [31:0] i1, input logic [31:0] p1,
                       input logic il1, input int take, input logic fl, input logic rs);
    logic [1:0] exp_ov;
    logic       exp_rdy;
    int         nin;
    sb_t        e;
    exp_rdy = (mcount <= DEPTH - WIDTH);
    exp_ov  = {mcount > 1, mcount > 0};
    n_tests++;
    if (in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_ready: got %b want %b (model count %0d)", in_ready, exp_rdy, mcount);
    end
    n_tests++;
    if (out_valid !== exp_ov) begin
      n_fail++;
      $display("FAIL out_valid: got %b want %b", out_valid, exp_ov);
    end
    if (!fl && !rs) begin
      for (int i = 0; i < take; i++) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underflow: got take lane %0d want an expected entry", i);
        end else begin
          e = sb.pop_front();
          if (out_entry[i].pc !== e.pc || out_entry[i].instr !== e.instr ||
              out_entry[i].illegal !== e.illegal) begin
            n_fail++;
            $display("FAIL entry lane%0d: got pc=%h instr=%h ill=%b want pc=%h instr=%h ill=%b",
                     i, out_entry[i].pc, out_entry[i].instr, out_entry[i].illegal,
                     e.pc, e.instr, e.illegal);
          end
        end
      end
    end
    nin = 0;
    if (exp_rdy && !fl && !rs) nin = vld[0] ? (vld[1] ? 2 : 1) : 0;
    if (nin > 0) sb.push_back('{pc: p0, instr: i0, illegal: il0});
    if (nin > 1) sb.push_back('{pc: p1, instr: i1, illegal: il1});
    if (fl || rs) begin
      mcount = 0;
      sb.delete();
    end else begin
      mcount = mcount + nin - take;
    end
    in_valid    = vld;
    in_instr[0] = i0;
    in_instr[1] = i1;
    in_pc[0]    = p0;
    in_pc[1]    = p1;
    out_take    = 2'(take);
    flush       = fl;
    rst         = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int take);
    cycle(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, take, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 2'b00 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags: got out_valid=%b in_ready=%b want 00/1", out_valid, in_ready);
    end
    n_tests++;
    if (out_entry !== '0) begin
      n_fail++;
      $display("FAIL reset_entry: got %h want 0", out_entry);
    end
    n_tests++;
    if (dut.count_q !== 4'd0 || dut.head_q !== 3'd0 || dut.tail_q !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ptrs: got cnt=%0d head=%0d tail=%0d want 0/0/0",
               dut.count_q, dut.head_q, dut.tail_q);
    end
    mcount = 0;
  endtask

  task automatic test_decode();
    cycle(2'b11, ADDI, 32'h0, 1'b0, SUB, 32'h4, 1'b0, 0, 1'b0, 1'b0);
    n_tests++;
    if (out_valid !== 2'b11 || out_entry[0].ctrl.aluop !== alu_add ||
        out_entry[1].ctrl.aluop !== alu_sub) begin
      n_fail++;
      $display("FAIL decode_alu: got ov=%b op0=%0d op1=%0d want 11/%0d/%0d", out_valid,
               out_entry[0].ctrl.aluop, out_entry[1].ctrl.aluop, alu_add, alu_sub);
    end
    n_tests++;
    if ({out_entry[1].illegal, out_entry[0].illegal} !== 2'b00 ||
        out_entry[0].ctrl.load_regfile !== 1'b1 || out_entry[0].ctrl.alumux2_sel !== a2_i_imm) begin
      n_fail++;
      $display("FAIL decode_addi: got ill=%b%b ldrf=%b a2=%0d want 00/1/%0d",
               out_entry[1].illegal, out_entry[0].illegal, out_entry[0].ctrl.load_regfile,
               out_entry[0].ctrl.alumux2_sel, a2_i_imm);
    end
    idle(2);
  endtask

  task automatic test_full();
    for (int g = 0; g < 5; g++)
      cycle(2'b11, ADDI, 32'h100 + 32'(8 * g), 1'b0, SUB, 32'h104 + 32'(8 * g), 1'b0,
            0, 1'b0, 1'b0);
    n_tests++;
    if (in_ready !== 1'b0 || dut.count_q !== 4'd8) begin
      n_fail++;
      $display("FAIL full: got in_ready=%b cnt=%0d want 0/8", in_ready, dut.count_q);
    end
    idle(1);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_minus1: got in_ready=%b want 0", in_ready);
    end
    idle(1);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_minus2: got in_ready=%b want 1", in_ready);
    end
    repeat (3) idle(2);
  endtask

  task automatic test_partial();
    logic [2:0] t0;
    t0 = dut.tail_q;
    cycle(2'b10, ADDI, 32'h200, 1'b0, ADDI, 32'h204, 1'b0, 0, 1'b0, 1'b0);
    n_tests++;
    if (out_valid !== 2'b00 || dut.tail_q !== t0) begin
      n_fail++;
      $display("FAIL partial_10: got ov=%b tail=%0d want 00/%0d", out_valid, dut.tail_q, t0);
    end
    cycle(2'b01, SUB, 32'h208, 1'b0, ADDI, 32'h20C, 1'b0, 0, 1'b0, 1'b0);
    n_tests++;
    if (out_valid !== 2'b01 || dut.tail_q !== 3'(t0 + 3'd1)) begin
      n_fail++;
      $display("FAIL partial_01: got ov=%b tail=%0d want 01/%0d", out_valid, dut.tail_q,
               3'(t0 + 3'd1));
    end
    idle(1);
  endtask

  task automatic test_stream();
    for (int g = 0; g < 10; g++) begin
      cycle(2'b11, ADDI, 32'(8 * g), 1'b0, SUB, 32'(8 * g + 4), 1'b0, (g == 0) ? 0 : 2,
            1'b0, 1'b0);
      n_tests++;
      if (dut.count_q !== 4'd2 || out_valid !== 2'b11) begin
        n_fail++;
        $display("FAIL stream_count g%0d: got cnt=%0d ov=%b want 2/11", g, dut.count_q, out_valid);
      end
    end
    idle(2);
  endtask

  task automatic test_flush();
    cycle(2'b11, ADDI, 32'h300, 1'b0, ADDI, 32'h304, 1'b0, 0, 1'b0, 1'b0);
    cycle(2'b11, ADDI, 32'h308, 1'b0, ADDI, 32'h30C, 1'b0, 0, 1'b0, 1'b0);
    cycle(2'b01, ADDI, 32'h310, 1'b0, ADDI, 32'h314, 1'b0, 0, 1'b0, 1'b0);
    n_tests++;
    if (dut.count_q !== 4'd5) begin
      n_fail++;
      $display("FAIL flush_pre: got cnt=%0d want 5", dut.count_q);
    end
    cycle(2'b11, ADDI, 32'h318, 1'b0, ADDI, 32'h31C, 1'b0, 2, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 2'b00 || in_ready !== 1'b1 || dut.count_q !== 4'd0 ||
        dut.head_q !== 3'd0 || dut.tail_q !== 3'd0) begin
      n_fail++;
      $display("FAIL flush: got ov=%b rdy=%b cnt=%0d head=%0d tail=%0d want 00/1/0/0/0",
               out_valid, in_ready, dut.count_q, dut.head_q, dut.tail_q);
    end
    cycle(2'b11, ADDI, 32'h320, 1'b0, SUB, 32'h324, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_reset_midburst();
    cycle(2'b11, ADDI, 32'h400, 1'b0, ADDI, 32'h404, 1'b0, 0, 1'b0, 1'b0);
    cycle(2'b11, ADDI, 32'h408, 1'b0, ADDI, 32'h40C, 1'b0, 0, 1'b0, 1'b0);
    cycle(2'b11, ADDI, 32'h410, 1'b0, ADDI, 32'h414, 1'b0, 2, 1'b0, 1'b1);
    n_tests++;
    if (out_valid !== 2'b00 || out_entry !== '0 || dut.count_q !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got ov=%b cnt=%0d want 00/0", out_valid, dut.count_q);
    end
  endtask

  task automatic test_mul();
    cycle(2'b11, MUL, 32'h500, MUL_ILL, BADOP, 32'h504, 1'b1, 0, 1'b0, 1'b0);
`ifdef RV32M_EN
    n_tests++;
    if (out_entry[0].ctrl.multiplier_start !== 1'b1 || out_entry[0].illegal !== 1'b0 ||
        out_entry[0].ctrl.regfilemux_sel !== regfilemux::mul) begin
      n_fail++;
      $display("FAIL mul_m: got mstart=%b ill=%b rfm=%0d want 1/0/%0d",
               out_entry[0].ctrl.multiplier_start, out_entry[0].illegal,
               out_entry[0].ctrl.regfilemux_sel, regfilemux::mul);
    end
`else
    n_tests++;
    if (out_entry[0].illegal !== 1'b1 || out_entry[0].ctrl.load_regfile !== 1'b0 ||
        out_entry[0].ctrl.multiplier_start !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_nom: got ill=%b ldrf=%b mstart=%b want 1/0/0", out_entry[0].illegal,
               out_entry[0].ctrl.load_regfile, out_entry[0].ctrl.multiplier_start);
    end
`endif
    n_tests++;
    if (out_entry[1].illegal !== 1'b1 || out_entry[1].ctrl.commit !== 1'b1 ||
        out_entry[1].ctrl.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL badop: got ill=%b commit=%b rdv=%b want 1/1/0", out_entry[1].illegal,
               out_entry[1].ctrl.commit, out_entry[1].ctrl.rd_valid);
    end
    idle(2);
  endtask

  task automatic test_decode_misc();
    cycle(2'b11, LW, 32'h600, 1'b0, LWBAD, 32'h604, 1'b1, 0, 1'b0, 1'b0);
    n_tests++;
    if (out_entry[0].ctrl.regfilemux_sel !== regfilemux::lw || out_entry[0].ctrl.mem_read !== 1'b1 ||
        out_entry[1].ctrl.mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL load: got rfm=%0d rd0=%b rd1=%b want %0d/1/0",
               out_entry[0].ctrl.regfilemux_sel, out_entry[0].ctrl.mem_read,
               out_entry[1].ctrl.mem_read, regfilemux::lw);
    end
    idle(2);
    cycle(2'b11, SW, 32'h608, 1'b0, SWBAD, 32'h60C, 1'b1, 0, 1'b0, 1'b0);
    n_tests++;
    if (out_entry[0].ctrl.mem_write !== 1'b1 || out_entry[1].ctrl.mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL store: got wr0=%b wr1=%b want 1/0", out_entry[0].ctrl.mem_write,
               out_entry[1].ctrl.mem_write);
    end
    idle(2);
    cycle(2'b11, SLT, 32'h610, 1'b0, ECALL, 32'h614, 1'b0, 0, 1'b0, 1'b0);
    n_tests++;
    if (out_entry[0].ctrl.regfilemux_sel !== regfilemux::br_en ||
        out_entry[0].ctrl.cmpop !== blt) begin
      n_fail++;
      $display("FAIL slt: got rfm=%0d cmp=%0d want %0d/%0d", out_entry[0].ctrl.regfilemux_sel,
               out_entry[0].ctrl.cmpop, regfilemux::br_en, blt);
    end
    idle(2);
    cycle(2'b11, SRAI, 32'h618, 1'b0, SLLBAD, 32'h61C, 1'b1, 0, 1'b0, 1'b0);
    n_tests++;
    if (out_entry[0].ctrl.aluop !== alu_sra || out_entry[1].ctrl.load_regfile !== 1'b0) begin
      n_fail++;
      $display("FAIL shift: got op=%0d ldrf1=%b want %0d/0", out_entry[0].ctrl.aluop,
               out_entry[1].ctrl.load_regfile, alu_sra);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_full();
    test_partial();
    test_stream();
    test_flush();
    test_reset_midburst();
    test_mul();
    test_decode_misc();
    idle(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage between fetch and issue. Accepts up to WIDTH fetched RV32 instructions per cycle and decodes each into an `rv32i_ctrl_word` plus an illegal-instruction flag. Decoded entries are stored in a circular buffer of DEPTH entries and presented in order to issue, up to WIDTH per cycle. Flush support covers branch/jump redirect.

## Interface
- WIDTH, 2: lanes per cycle in and out; 1..4.
- DEPTH, 8: buffer entries; power of two, ≥ 2*WIDTH.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all buffered and incoming entries.
- in_valid  in  WIDTH  per-lane fetch valid; prefix-contiguous from lane 0.
- in_instr  in  WIDTH×32  instruction words.
- in_pc  in  WIDTH×32  instruction PCs.
- in_ready  out  1  buffer can accept a full WIDTH group this cycle.
- out_valid  out  WIDTH  lane i holds a valid entry; prefix-contiguous.
- out_entry  out  WIDTH×decode_entry_t  pc, instr, ctrl, illegal for the i-th oldest entry.
- out_take  in  $clog2(WIDTH+1)  number of lanes consumed by issue this cycle.

## Operation
- State: head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; count register 0..DEPTH; entry array.
- Enqueue:
  - n_in = number of leading set bits of in_valid when in_ready=1, else 0.
  - Lanes after the first clear bit are ignored.
  - Lane k is decoded combinationally and written at tail+k; tail advances by n_in.
- Decode rules:
  - LUI, AUIPC, JAL, JALR, BR, LOAD, STORE, OP-IMM and OP follow the RV32I control encoding of `rv32i_ctrl_word`.
  - Shift type is selected by funct7[5]. On OP, funct7[5] also selects add/sub.
  - SLT/SLTU route through the comparator with `regfilemux::br_en`.
  - Loads select regfilemux lb/lh/lw/lbu/lhu.
- Illegal when any of the following holds:
  - unknown opcode;
  - load funct3 ∈ {011,110,111};
  - store funct3 ≥ 011;
  - OP funct7 ∉ {0000000, 0100000 with funct3 ∈ {000,101}, M encodings};
  - OP-IMM shift with funct7 ∉ {0000000, 0100000 (sr only)}.
- Illegal entries carry load_regfile=0, mem_read=0, mem_write=0, multiplier_start=0, divider_start=0, rd_valid=0, commit=1, illegal=1.
- CSR opcode decodes as a defaulted no-op, not illegal.
- Dequeue:
  - out_valid[i] = (count > i).
  - out_entry[i] = entry[head+i].
  - n_out = min(out_take, count, WIDTH); head advances by n_out.
  - out_take exceeding the valid count is a protocol violation: assertion fires, RTL clamps.
- Count update: count_next = count + n_in − n_out. Simultaneous enqueue and dequeue is legal in every state, including full and empty.
- Flush:
  - Next cycle count=0 and head=tail=0.
  - Same-cycle enqueue is dropped; same-cycle out_take is ignored.
- Reset:
  - count=0, head=tail=0, out_valid=0, in_ready=1.
  - Entry contents are don't-care, but out_entry must be all-zero when out_valid=0.
  - Reset mid-burst behaves as flush and overrides everything.

## Timing
- Accept to out_valid: 1 cycle. No same-cycle bypass.
- in_ready = (DEPTH − count) ≥ WIDTH, derived only from registered count. There is no combinational path from out_take to in_ready, so a slot freed in cycle t is usable at t+1.
- out_valid and out_entry are driven from registers through the read mux only; the decoder sits on the write side.
- Throughput: WIDTH instructions per cycle sustained when issue takes WIDTH per cycle.
- Full: count > DEPTH − WIDTH drops in_ready even though fewer than WIDTH slots remain.

## Configuration
- RV32M_EN defined:
  - OP with funct7=0000001 decodes MUL/MULH/MULHSU/MULHU (multiplier_start, regfilemux mul or mulh) and DIV/DIVU/REM/REMU (divider_start, regfilemux div or rem).
- RV32M_EN undefined:
  - Those encodings are illegal.
  - multiplier_start and divider_start are tied 0.

## Structure
- Add to `rv32i_types`:
  - decode_entry_t: pc, instr, ctrl, illegal.
  - DECODE_WIDTH_MAX = 4.
- One combinational sub-module `rv32_decoder` (instr → ctrl, illegal), instantiated WIDTH times on the write side.
- The queue logic stays in decode_queue.

## Test plan
1. WIDTH=2, DEPTH=8; reset; enqueue ADDI x1,x0,5 (0x00500093) and SUB x2,x1,x1 (0x40108133) with out_take=0 → next cycle out_valid=11, lane0 aluop=alu_add, lane1 aluop=alu_sub, illegal=00.
2. Fill with out_take=0 for 4 cycles → count=8, in_ready=0 from cycle 4. Fifth group is not accepted. out_take=1 for one cycle → in_ready still 0 (count 7 > 6). A second out_take=1 → in_ready=1.
3. in_valid=10 → nothing enqueued. in_valid=01 → one entry enqueued, tail+1.
4. Ten groups streamed with out_take=2 every cycle → pointers wrap past 7. Output order equals input PC order (0x0, 0x4, …, 0x4C). count is constant at 2 after the first cycle.
5. flush asserted with count=5 while in_valid=11 and out_take=2 → next cycle out_valid=00, count=0, in_ready=1.
6. MUL (0x02208033): with RV32M_EN → multiplier_start=1, illegal=0. Without RV32M_EN → illegal=1, load_regfile=0. Opcode 0x7F → illegal=1 in both builds.
